// File: rtl/vga_segdac_driver.sv
`default_nettype none
// ============================================================================
// Module   : vga_segdac_driver
// Brief    : VGA 640x480@60 timing generator and 8-bit to 12-switch segment
//            DAC encoder with a two-stage output pipeline. The optional
//            colour-bar test pattern is enabled by macro VGA_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_segdac_driver #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        frame_start,
  output logic [11:0] R,
  output logic [11:0] G,
  output logic [11:0] B,
  output logic        hsync,
  output logic        vsync,
  output logic        blank
);

  localparam logic [9:0] c_H_VIS    = 10'(H_VIS);
  localparam logic [9:0] c_HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_VIS    = 10'(V_VIS);
  localparam logic [9:0] c_VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] c_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  // ---------------------------------------------------------------- stage 0
  logic [9:0] r_hpos;
  logic [9:0] r_vpos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (r_hpos == c_H_LAST) begin
      r_hpos <= '0;
      r_vpos <= (r_vpos == c_V_LAST) ? 10'd0 : r_vpos + 10'd1;
    end else begin
      r_hpos <= r_hpos + 10'd1;
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign frame_start = (r_hpos == 10'd0) && (r_vpos == 10'd0);

  // ---------------------------------------------------------------- stage 1
  logic        w_vis;
  logic        w_hs_n;
  logic        w_vs_n;
  logic [23:0] w_pix;

  always_comb begin
    w_vis  = (r_hpos < c_H_VIS) && (r_vpos < c_V_VIS);
    w_hs_n = !((r_hpos >= c_HS_FIRST) && (r_hpos <= c_HS_LAST));
    w_vs_n = !((r_vpos >= c_VS_FIRST) && (r_vpos <= c_VS_LAST));
  end

`ifdef VGA_TEST_PATTERN_EN
  // Eight vertical bars from hpos[9:7], with a vertical ramp in the red LSBs.
  logic [2:0]  w_bar;
  logic [23:0] w_pattern;

  assign w_bar     = r_hpos[9:7];
  assign w_pattern = {{6{w_bar[2]}}, r_vpos[8:7], {8{w_bar[1]}}, {8{w_bar[0]}}};
  assign w_pix     = pattern_sel ? w_pattern : rgb_in;
`else
  assign w_pix = rgb_in;
`endif

  logic        r_vis1;
  logic        r_hs1_n;
  logic        r_vs1_n;
  logic [23:0] r_pix1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vis1  <= 1'b0;
      r_hs1_n <= 1'b1;
      r_vs1_n <= 1'b1;
      r_pix1  <= '0;
    end else begin
      r_vis1  <= w_vis;
      r_hs1_n <= w_hs_n;
      r_vs1_n <= w_vs_n;
      r_pix1  <= w_pix;
    end
  end

  // ---------------------------------------------------------------- stage 2
  // Each 2-bit field n closes n of its segment's three switches.
  function automatic logic [11:0] seg_encode(input logic [7:0] c);
    logic [11:0] code;
    logic [1:0]  f;
    code = '0;
    for (int s = 0; s < 4; s++) begin
      f = c[2*s +: 2];
      code[3*s +: 3] = {f[1] & f[0], f[1], f[1] | f[0]};
    end
    return code;
  endfunction

  logic [11:0] w_code [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign w_code[gi] = r_vis1 ? seg_encode(r_pix1[8*(2-gi) +: 8]) : 12'd0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      R     <= '0;
      G     <= '0;
      B     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
    end else begin
      R     <= w_code[0];
      G     <= w_code[1];
      B     <= w_code[2];
      hsync <= r_hs1_n;
      vsync <= r_vs1_n;
      blank <= !r_vis1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_segdac_driver.sv
`default_nettype none
// Bench for vga_segdac_driver: random pixels against a behavioural model,
// plus literal checks for encoding, reset, alignment and pulse widths.
module tb_vga_segdac_driver;

  localparam int H_TOT  = 800;
  localparam int V_VIS  = 20;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rgb_in = '0;
  logic        pattern_sel = 1'b0;
  logic [9:0]  hpos, vpos;
  logic        frame_start, hsync, vsync, blank;
  logic [11:0] R, G, B;

  vga_segdac_driver #(
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .hpos(hpos), .vpos(vpos), .frame_start(frame_start),
    .R(R), .G(G), .B(B), .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct packed {
    logic [11:0] r, g, b;
    logic        hs, vs, bl;
  } out_t;

  localparam out_t RST_OUT = '{r: 12'd0, g: 12'd0, b: 12'd0, hs: 1'b1, vs: 1'b1, bl: 1'b1};

  function automatic logic [11:0] therm(input logic [7:0] c);
    logic [11:0] o;
    int n;
    o = '0;
    for (int s = 0; s < 4; s++) begin
      n = int'((c >> (2 * s)) & 8'd3);
      o = o | 12'(((1 << n) - 1) << (3 * s));
    end
    return o;
  endfunction

  function automatic out_t predict(input int h, input int v, input logic [23:0] px, input logic ps);
    out_t o;
    logic [23:0] p;
    int bar;
    bit vis;
    p = px;
    if (PAT_EN && ps) begin
      bar = h / 128;
      p[23:16] = ((bar >= 4) ? 8'hFC : 8'h00) | 8'((v / 128) % 4);
      p[15:8]  = ((bar / 2) % 2 == 1) ? 8'hFF : 8'h00;
      p[7:0]   = (bar % 2 == 1) ? 8'hFF : 8'h00;
    end
    vis  = (h < 640) && (v < V_VIS);
    o.hs = !(h >= 656 && h < 752);
    o.vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    o.bl = !vis;
    o.r  = vis ? therm(p[23:16]) : 12'd0;
    o.g  = vis ? therm(p[15:8])  : 12'd0;
    o.b  = vis ? therm(p[7:0])   : 12'd0;
    return o;
  endfunction

  out_t exp_o, pend;
  int   m_h = 0, m_v = 0;
  bit   model_rst = 1'b0, model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_h = 0; m_v = 0;
      exp_o = RST_OUT; pend = RST_OUT;
      model_rst = 1'b1; model_valid = 1'b1;
    end else begin
      exp_o = pend;
      pend  = predict(m_h, m_v, rgb_in, pattern_sel);
      m_h++;
      if (m_h == H_TOT) begin
        m_h = 0;
        m_v = (m_v + 1) % V_TOT;
      end
      model_rst = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("hpos", 32'(hpos), 32'(m_h));
      check("vpos", 32'(vpos), 32'(m_v));
      check("frame_start", 32'(frame_start), 32'(m_h == 0 && m_v == 0));
      check("R", 32'(R), 32'(exp_o.r));
      check("G", 32'(G), 32'(exp_o.g));
      check("B", 32'(B), 32'(exp_o.b));
      check("hsync", 32'(hsync), 32'(exp_o.hs));
      check("vsync", 32'(vsync), 32'(exp_o.vs));
      check("blank", 32'(blank), 32'(exp_o.bl));
    end
  end

  // ------------------------------------------------------------ pulse widths
  int  fs_cnt = 0, hrun = 0, vrun = 0;
  bit  fs_have = 1'b0;

  always @(negedge clk) begin
    if (model_valid) begin
      if (model_rst) begin
        fs_have = 1'b1; fs_cnt = 1; hrun = 0; vrun = 0;
      end else begin
        if (frame_start) begin
          if (fs_have) check("frame_interval", 32'(fs_cnt), 32'(H_TOT * V_TOT));
          fs_have = 1'b1; fs_cnt = 1;
        end else begin
          fs_cnt++;
        end
        if (!hsync) hrun++;
        else if (hrun > 0) begin check("hsync_width", 32'(hrun), 32'd96); hrun = 0; end
        if (!vsync) vrun++;
        else if (vrun > 0) begin check("vsync_width", 32'(vrun), 32'd1600); vrun = 0; end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic wait_pos(input int h, input int v);
    int k;
    k = 0;
    while (!(hpos == 10'(h) && vpos == 10'(v)) && k < 30000) begin
      rgb_in = $urandom;
      @(negedge clk);
      k++;
    end
    if (k >= 30000) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_pos(%0d,%0d): timed out, hpos=%0d vpos=%0d", h, v, hpos, vpos);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22000; i++) begin
      rgb_in = $urandom;
      pattern_sel = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pattern_sel = 1'b0;

    // Encoding example
    wait_pos(10, 5);
    rgb_in = 24'hE41BFF;
    @(negedge clk); rgb_in = $urandom;
    @(negedge clk);
    check("lit_R", 32'(R), 32'(12'b111_011_001_000));
    check("lit_G", 32'(G), 32'(12'b000_001_011_111));
    check("lit_B", 32'(B), 32'(12'hFFF));
    check("lit_blank", 32'(blank), 32'd0);

    // Last visible pixel alignment
    wait_pos(637, 8);
    rgb_in = 24'h0;
    @(negedge clk); rgb_in = 24'h0;
    @(negedge clk); rgb_in = 24'h030303;
    @(negedge clk); rgb_in = 24'h0;
    check("align_prev_R", 32'(R), 32'd0);
    @(negedge clk);
    check("align_R", 32'(R), 32'(12'b000_000_000_111));
    check("align_G", 32'(G), 32'(12'b000_000_000_111));
    check("align_B", 32'(B), 32'(12'b000_000_000_111));
    check("align_blank", 32'(blank), 32'd0);
    @(negedge clk);
    check("align_after_blank", 32'(blank), 32'd1);
    check("align_after_R", 32'(R), 32'd0);

    // Mid-frame reset during vsync
    wait_pos(700, V_VIS + V_FP + 1);
    check("pre_rst_vsync", 32'(vsync), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_hpos", 32'(hpos), 32'd0);
    check("rst_vpos", 32'(vpos), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_RGB", 32'({R, G, B}), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd1);
    rst = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    wait_pos(384, 0);
    pattern_sel = 1'b1;
    @(negedge clk); pattern_sel = 1'b0;
    @(negedge clk);
    check("pat_R", 32'(R), 32'(12'h000));
    check("pat_G", 32'(G), 32'(12'hFFF));
    check("pat_B", 32'(B), 32'(12'hFFF));
`endif

    repeat (200) begin
      rgb_in = $urandom;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
